// File: rtl/gio_input_capture.sv
// GIO input capture: per-pin 2-flop synchronizer, counter debounce, rising-edge
// press detection into sticky flags, and a clear-on-read CPU snapshot port.
module gio_input_capture #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     GIO_pins,
  input  logic                 rd_en,
  output logic [2*WIDTH-1:0]   rd_data,
  output logic                 rd_valid,
  output logic [WIDTH-1:0]     level,
  output logic                 press_pending,
  output logic                 overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] level_next;
  logic [WIDTH-1:0] new_press;
  logic [WIDTH-1:0] press_flags;
  logic [WIDTH-1:0] clr_mask;
  logic             overrun_set;

  // Press detection uses the debounce next-state so flags land on the same
  // edge as the level update, letting a coincident read see the pre-edge view.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_next[i]   = '0;
      level_next[i] = level[i];
      if (s2[i] != level[i]) begin
        if (cnt[i] == CNT_MAX) begin
          level_next[i] = s2[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
    new_press   = level_next & ~level;
    clr_mask    = rd_en ? press_flags : '0;
    overrun_set = |(new_press & press_flags & ~clr_mask);
  end

  assign press_pending = |press_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= '0;
      s2          <= '0;
      level       <= '0;
      press_flags <= '0;
      overrun     <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1          <= GIO_pins;
      s2          <= s1;
      level       <= level_next;
      press_flags <= (press_flags & ~clr_mask) | new_press;
      overrun     <= (overrun & ~rd_en) | overrun_set;
      rd_valid    <= rd_en;
      if (rd_en) begin
        rd_data <= {press_flags, level};
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_gio_input_capture.sv
// Directed bench for gio_input_capture with a short debounce window (4 cycles),
// so a clean pin step reaches level 6 clock edges after the pin changes.
module tb_gio_input_capture;

  logic        clk;
  logic        reset;
  logic [7:0]  GIO_pins;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [7:0]  level;
  logic        press_pending;
  logic        overrun;

  int n_checks;
  int n_fail;

  gio_input_capture #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .GIO_pins      (GIO_pins),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .level         (level),
    .press_pending (press_pending),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    GIO_pins = 8'h00;
    rd_en    = 1'b0;
    tick(3);
    n_checks++;
    if ({rd_data, rd_valid, level, press_pending, overrun} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd_data=%h rd_valid=%b level=%h pend=%b ovr=%b, expected all zero",
               rd_data, rd_valid, level, press_pending, overrun);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_press;
    GIO_pins = 8'h01;
    tick(5);
    n_checks++;
    if (level !== 8'h00) begin
      n_fail++;
      $display("FAIL press_latency_early: level=%h expected %h", level, 8'h00);
    end
    tick();
    n_checks++;
    if (level !== 8'h01) begin
      n_fail++;
      $display("FAIL press_latency: level=%h expected %h", level, 8'h01);
    end
    n_checks++;
    if (press_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL press_pending_set: got %b expected 1", press_pending);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rd_data !== 16'h0101 || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_read: rd_data=%h rd_valid=%b expected 0101/1", rd_data, rd_valid);
    end
    n_checks++;
    if (press_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_on_read: press_pending=%b expected 0", press_pending);
    end
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0101) begin
      n_fail++;
      $display("FAIL read_hold: rd_data=%h rd_valid=%b expected 0101/0", rd_data, rd_valid);
    end
  endtask

  task automatic test_bounce;
    GIO_pins = 8'h00;
    tick(6);
    n_checks++;
    if (level !== 8'h00 || press_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL release_no_flag: level=%h pend=%b expected 00/0", level, press_pending);
    end
    GIO_pins = 8'h08; tick(3);
    GIO_pins = 8'h00; tick(1);
    GIO_pins = 8'h08; tick(3);
    GIO_pins = 8'h00; tick(8);
    n_checks++;
    if (level !== 8'h00 || press_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_rejected: level=%h pend=%b expected 00/0", level, press_pending);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rd_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL bounce_read: rd_data=%h expected 0000", rd_data);
    end
  endtask

  task automatic test_simultaneous;
    GIO_pins = 8'h01;
    tick(6);
    GIO_pins = 8'h21;
    tick(5);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rd_data !== 16'h0101) begin
      n_fail++;
      $display("FAIL coincident_read: rd_data=%h expected 0101", rd_data);
    end
    n_checks++;
    if (level !== 8'h21 || press_pending !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL coincident_retained: level=%h pend=%b ovr=%b expected 21/1/0",
               level, press_pending, overrun);
    end
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rd_data !== 16'h2021) begin
      n_fail++;
      $display("FAIL coincident_next_read: rd_data=%h expected 2021", rd_data);
    end
  endtask

  task automatic test_overrun;
    GIO_pins = 8'h25; tick(6);
    n_checks++;
    if (overrun !== 1'b0 || press_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_first_press: ovr=%b pend=%b expected 0/1", overrun, press_pending);
    end
    GIO_pins = 8'h21; tick(6);
    GIO_pins = 8'h25; tick(6);
    n_checks++;
    if (overrun !== 1'b1 || level !== 8'h25) begin
      n_fail++;
      $display("FAIL overrun_set: ovr=%b level=%h expected 1/25", overrun, level);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (overrun !== 1'b0 || rd_data !== 16'h0425) begin
      n_fail++;
      $display("FAIL overrun_clear: ovr=%b rd_data=%h expected 0/0425", overrun, rd_data);
    end
  endtask

  task automatic test_reset_mid_debounce;
    GIO_pins = 8'h00; tick(6);
    GIO_pins = 8'h80; tick(4);
    reset = 1'b1;
    tick();
    n_checks++;
    if ({rd_data, rd_valid, level, press_pending, overrun} !== 27'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: rd_data=%h rd_valid=%b level=%h pend=%b ovr=%b expected all zero",
               rd_data, rd_valid, level, press_pending, overrun);
    end
    reset = 1'b0;
    tick(5);
    n_checks++;
    if (level !== 8'h00) begin
      n_fail++;
      $display("FAIL post_reset_early: level=%h expected 00", level);
    end
    tick();
    n_checks++;
    if (level !== 8'h80 || press_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_press: level=%h pend=%b expected 80/1", level, press_pending);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rd_data !== 16'h8080) begin
      n_fail++;
      $display("FAIL post_reset_read: rd_data=%h expected 8080", rd_data);
    end
  endtask

  task automatic test_multi_bit;
    GIO_pins = 8'h00; tick(6);
    GIO_pins = 8'hA5; tick(5);
    n_checks++;
    if (level !== 8'h00) begin
      n_fail++;
      $display("FAIL multi_early: level=%h expected 00", level);
    end
    tick();
    n_checks++;
    if (level !== 8'hA5) begin
      n_fail++;
      $display("FAIL multi_level: level=%h expected A5", level);
    end
  endtask

  task automatic test_back_to_back;
    rd_en = 1'b1;
    tick();
    n_checks++;
    if (rd_data !== 16'hA5A5 || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: rd_data=%h rd_valid=%b expected A5A5/1", rd_data, rd_valid);
    end
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rd_data !== 16'h00A5 || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: rd_data=%h rd_valid=%b expected 00A5/1", rd_data, rd_valid);
    end
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h00A5) begin
      n_fail++;
      $display("FAIL b2b_idle: rd_data=%h rd_valid=%b expected 00A5/0", rd_data, rd_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    GIO_pins = 8'h00;
    rd_en    = 1'b0;
    test_reset;
    test_single_press;
    test_bounce;
    test_simultaneous;
    test_overrun;
    test_reset_mid_debounce;
    test_multi_bit;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
